// File: rtl/imem_dmem_port_arbiter_if.sv
`timescale 1ns/1ps
// Bundle for the arbiter's core-side (IF/MEM stage) and memory-side signals.
// The slave modport is the arbiter's view; master is the core plus memory model.
interface imem_dmem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_flush;
    logic [DW-1:0]   if_rdata;
    logic            if_valid;
    logic            if_stall;

    logic            dm_req;
    logic            dm_we;
    logic [AW-1:0]   dm_addr;
    logic [DW-1:0]   dm_wdata;
    logic [DW/8-1:0] dm_be;
    logic [DW-1:0]   dm_rdata;
    logic            dm_valid;
    logic            dm_stall;

    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_rdata, if_valid, if_stall,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output dm_rdata, dm_valid, dm_stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_rdata, if_valid, if_stall,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  dm_rdata, dm_valid, dm_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/imem_dmem_port_arbiter.sv
`timescale 1ns/1ps
// Shares one memory port between IF fetch and MEM load/store, one transaction at a time.
// Defining ARB_PERF_CNT_EN adds saturating stall-cycle counters.
module imem_dmem_port_arbiter #(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic clk,
    input  logic rst_n,
    imem_dmem_port_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0] perf_if_stall_cyc,
    output logic [31:0] perf_dm_stall_cyc
`endif
);
    typedef enum logic [2:0] {IDLE, REQ_D, REQ_I, RSP_D, RSP_I} state_t;

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    state_t          state;
    logic [SW-1:0]   streak;
    logic            kill;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic [DW-1:0]   if_rdata;
    logic [DW-1:0]   dm_rdata;
    logic            if_valid;
    logic            dm_valid;
    logic            if_stall;
    logic            dm_stall;
    logic            pick_d;
    logic            pick_i;

    // Data wins unless a pending fetch has already watched MAX_DATA_STREAK data grants.
    always_comb begin
        pick_d = 1'b0;
        pick_i = 1'b0;
        if (state == IDLE) begin
            if (bus.dm_req && !(bus.if_req && streak == STREAK_MAX)) begin
                pick_d = 1'b1;
            end else if (bus.if_req && !bus.if_flush) begin
                pick_i = 1'b1;
            end
        end
    end

    assign if_stall = bus.if_req & ~if_valid;
    assign dm_stall = bus.dm_req & ~dm_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            streak    <= '0;
            kill      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state     <= REQ_D;
                        mem_req   <= 1'b1;
                        mem_we    <= bus.dm_we;
                        mem_addr  <= bus.dm_addr;
                        mem_wdata <= bus.dm_wdata;
                        mem_be    <= bus.dm_be;
                    end else if (pick_i) begin
                        state     <= REQ_I;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= bus.if_addr;
                        mem_wdata <= '0;
                        mem_be    <= '1;
                    end
                end
                REQ_D: begin
                    if (bus.mem_gnt) begin
                        state   <= RSP_D;
                        mem_req <= 1'b0;
                    end
                end
                REQ_I: begin
                    if (bus.if_flush) begin
                        kill <= 1'b1;
                    end
                    if (bus.mem_gnt) begin
                        state   <= RSP_I;
                        mem_req <= 1'b0;
                    end
                end
                RSP_D: begin
                    // A store's ack carries no data, so the last load value is kept.
                    if (bus.mem_rvalid) begin
                        state    <= IDLE;
                        dm_valid <= 1'b1;
                        if (!mem_we) begin
                            dm_rdata <= bus.mem_rdata;
                        end
                    end
                end
                RSP_I: begin
                    if (bus.mem_rvalid) begin
                        state <= IDLE;
                        kill  <= 1'b0;
                        if (!(kill || bus.if_flush)) begin
                            if_rdata <= bus.mem_rdata;
                            if_valid <= 1'b1;
                        end
                    end else if (bus.if_flush) begin
                        kill <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (!bus.if_req || pick_i) begin
                streak <= '0;
            end else if (pick_d && streak != STREAK_MAX) begin
                streak <= streak + 1'b1;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_if_stall_cyc <= '0;
            perf_dm_stall_cyc <= '0;
        end else begin
            if (if_stall && perf_if_stall_cyc != 32'hFFFF_FFFF) begin
                perf_if_stall_cyc <= perf_if_stall_cyc + 32'd1;
            end
            if (dm_stall && perf_dm_stall_cyc != 32'hFFFF_FFFF) begin
                perf_dm_stall_cyc <= perf_dm_stall_cyc + 32'd1;
            end
        end
    end
`endif

    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_be    = mem_be;
    assign bus.if_rdata  = if_rdata;
    assign bus.dm_rdata  = dm_rdata;
    assign bus.if_valid  = if_valid;
    assign bus.dm_valid  = dm_valid;
    assign bus.if_stall  = if_stall;
    assign bus.dm_stall  = dm_stall;
endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
`timescale 1ns/1ps
// Directed vector bench for imem_dmem_port_arbiter with a configurable-latency memory model.
// Counter checks are compiled in when ARB_PERF_CNT_EN is defined.
module tb_imem_dmem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        bit          is_fetch;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          gw;
        int          rw;
        logic [31:0] rdata;
        int          exp_lat;
        bit          exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;
        logic [31:0] exp_other;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    int          gnt_delay = 0;
    int          rsp_delay = 0;
    logic [31:0] resp_data = '0;
    int          gnt_cnt = 0;
    int          rsp_cnt = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_data = '0;
    logic [31:0] grant_log[$];

    always #5 clk = ~clk;

    imem_dmem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_stall_cyc;
    logic [31:0] perf_dm_stall_cyc;
`endif

    imem_dmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DATA_STREAK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_if_stall_cyc (perf_if_stall_cyc),
        .perf_dm_stall_cyc (perf_dm_stall_cyc)
`endif
    );

    // Memory model: grants after gnt_delay waiting cycles, answers rsp_delay cycles after the grant cycle.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = '0;
            pend           = 1'b0;
            gnt_cnt        = 0;
        end else begin
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (pend) begin
                if (rsp_cnt == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = pend_data;
                    pend           = 1'b0;
                end else begin
                    rsp_cnt--;
                end
            end else if (bus.mem_req) begin
                if (gnt_cnt >= gnt_delay) begin
                    bus.mem_gnt = 1'b1;
                    pend        = 1'b1;
                    rsp_cnt     = rsp_delay;
                    pend_data   = resp_data;
                    gnt_cnt     = 0;
                    grant_log.push_back(bus.mem_addr);
                end else begin
                    gnt_cnt++;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic waitValid(input bit fetch, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk); #1;
            seen = fetch ? bus.if_valid : bus.dm_valid;
        end
        checkOutput(name, 32'(seen), 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        int          k = 0;
        bit          seen = 1'b0;
        bit          hold_ok = 1'b1;
        bit          stall_ok = 1'b1;
        logic [31:0] rdata_reg;
        logic [31:0] other_reg;
        gnt_delay  = v.gw;
        rsp_delay  = v.rw;
        resp_data  = v.rdata;
        bus.dm_we  = v.we;
        bus.dm_be  = v.be;
        if (v.is_fetch) begin
            bus.if_addr = v.addr;
            bus.if_req  = 1'b1;
        end else begin
            bus.dm_addr  = v.addr;
            bus.dm_wdata = v.wdata;
            bus.dm_req   = 1'b1;
        end
        #1;
        if ((v.is_fetch ? bus.if_stall : bus.dm_stall) !== 1'b1) stall_ok = 1'b0;
        while (!seen && k < 60) begin
            @(posedge clk); #1;
            k++;
            seen = v.is_fetch ? bus.if_valid : bus.dm_valid;
            if (!seen) begin
                if ((v.is_fetch ? bus.if_stall : bus.dm_stall) !== 1'b1) stall_ok = 1'b0;
                if (k <= 1 + v.gw) begin
                    if (bus.mem_req !== 1'b1 || bus.mem_we !== v.exp_we || bus.mem_addr !== v.addr ||
                        bus.mem_be !== v.exp_be || (!v.is_fetch && bus.mem_wdata !== v.wdata))
                        hold_ok = 1'b0;
                end else if (k == 2 + v.gw && bus.mem_req !== 1'b0) begin
                    hold_ok = 1'b0;
                end
            end
        end
        if (v.is_fetch) bus.if_req = 1'b0;
        else            bus.dm_req = 1'b0;
        rdata_reg = v.is_fetch ? bus.if_rdata : bus.dm_rdata;
        other_reg = v.is_fetch ? bus.dm_rdata : bus.if_rdata;
        checkOutput({name, "_latency"}, 32'(k), 32'(v.exp_lat));
        checkOutput({name, "_mem_fields"}, 32'(hold_ok), 32'd1);
        checkOutput({name, "_stall"}, 32'(stall_ok), 32'd1);
        checkOutput({name, "_rdata"}, rdata_reg, v.exp_rdata);
        checkOutput({name, "_other_rdata"}, other_reg, v.exp_other);
        @(posedge clk); #1;
        checkOutput({name, "_pulse_end"}, 32'(v.is_fetch ? bus.if_valid : bus.dm_valid), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        vec_t        vecs[5];
        logic [31:0] exp_addr;
`ifdef ARB_PERF_CNT_EN
        vec_t        perf_vec;
`endif
        vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,        4'hF, 0, 0, 32'hDEADBEEF, 3, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'h80,  32'h11223344, 4'h3, 5, 0, 32'hCAFEF00D, 8, 1'b1, 4'h3, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 32'h104, 32'h0,        4'h5, 1, 2, 32'h00A00093, 6, 1'b0, 4'hF, 32'h00A00093, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 1'b0, 32'h44,  32'h0,        4'hF, 2, 1, 32'h12345678, 6, 1'b0, 4'hF, 32'h12345678, 32'h00A00093};
        vecs[4] = '{1'b1, 1'b1, 32'h108, 32'h0,        4'h5, 0, 0, 32'h00000013, 3, 1'b0, 4'hF, 32'h00000013, 32'h12345678};

        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.if_flush = 1'b0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
        bus.dm_be    = '0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_mem_req",  32'(bus.mem_req),  32'd0);
        checkOutput("reset_mem_addr", bus.mem_addr,      32'd0);
        checkOutput("reset_mem_be",   32'(bus.mem_be),   32'd0);
        checkOutput("reset_if_valid", 32'(bus.if_valid), 32'd0);
        checkOutput("reset_dm_valid", 32'(bus.dm_valid), 32'd0);
        checkOutput("reset_if_rdata", bus.if_rdata,      32'd0);
        checkOutput("reset_dm_rdata", bus.dm_rdata,      32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Both requesters held: four data grants, then the starved fetch.
        grant_log.delete();
        gnt_delay    = 0;
        rsp_delay    = 0;
        resp_data    = 32'h00000013;
        bus.dm_addr  = 32'h40;
        bus.dm_we    = 1'b0;
        bus.dm_be    = 4'hF;
        bus.if_addr  = 32'h100;
        bus.dm_req   = 1'b1;
        bus.if_req   = 1'b1;
        for (int i = 0; i < 100 && grant_log.size() < 10; i++) begin
            @(posedge clk); #1;
        end
        bus.dm_req = 1'b0;
        bus.if_req = 1'b0;
        checkOutput("contention_count", 32'(grant_log.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            exp_addr = (i % 5 == 4) ? 32'h100 : 32'h40;
            checkOutput($sformatf("contention_grant%0d", i),
                        (i < grant_log.size()) ? grant_log[i] : 32'hFFFFFFFF, exp_addr);
        end
        repeat (8) @(posedge clk);
        #1;

        // Flush while the fetch waits for its response.
        grant_log.delete();
        gnt_delay   = 0;
        rsp_delay   = 3;
        resp_data   = 32'hBAD0BAD0;
        bus.if_addr = 32'h100;
        bus.if_req  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.if_flush = 1'b1;
        bus.if_addr  = 32'h200;
        resp_data    = 32'h00C0FFEE;
        @(posedge clk); #1;
        bus.if_flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("flush_killed_valid", 32'(bus.if_valid), 32'd0);
        checkOutput("flush_killed_rdata", bus.if_rdata, 32'h00000013);
        waitValid(1'b1, "flush_refetch_seen");
        bus.if_req = 1'b0;
        checkOutput("flush_refetch_rdata", bus.if_rdata, 32'h00C0FFEE);
        checkOutput("flush_grant_count", 32'(grant_log.size()), 32'd2);
        checkOutput("flush_refetch_addr", (grant_log.size() > 1) ? grant_log[1] : 32'hFFFFFFFF, 32'h200);
        @(posedge clk); #1;

        // A flush in IDLE only blocks fetch selection for that cycle.
        rsp_delay    = 0;
        resp_data    = 32'h00000204;
        bus.if_addr  = 32'h204;
        bus.if_flush = 1'b1;
        bus.if_req   = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_flush_block", 32'(bus.mem_req), 32'd0);
        bus.if_flush = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle_flush_release", 32'(bus.mem_req), 32'd1);
        waitValid(1'b1, "idle_flush_fetch_done");
        bus.if_req = 1'b0;
        checkOutput("idle_flush_rdata", bus.if_rdata, 32'h00000204);
        @(posedge clk); #1;

        // Reset while a load waits for its response.
        rsp_delay    = 10;
        resp_data    = 32'h55AA55AA;
        bus.dm_addr  = 32'h40;
        bus.dm_we    = 1'b0;
        bus.dm_wdata = 32'h11223344;
        bus.dm_req   = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_mem_req",   32'(bus.mem_req),  32'd0);
        checkOutput("midrst_mem_addr",  bus.mem_addr,      32'd0);
        checkOutput("midrst_mem_wdata", bus.mem_wdata,     32'd0);
        checkOutput("midrst_mem_be",    32'(bus.mem_be),   32'd0);
        checkOutput("midrst_dm_valid",  32'(bus.dm_valid), 32'd0);
        checkOutput("midrst_dm_rdata",  bus.dm_rdata,      32'd0);
        checkOutput("midrst_if_rdata",  bus.if_rdata,      32'd0);
        bus.dm_req = 1'b0;
        @(posedge clk); #1;
        rsp_delay   = 0;
        resp_data   = 32'h00000300;
        rst_n       = 1'b1;
        bus.if_addr = 32'h300;
        bus.if_req  = 1'b1;
        @(posedge clk); #1;
        checkOutput("postrst_mem_req",  32'(bus.mem_req), 32'd1);
        checkOutput("postrst_mem_addr", bus.mem_addr,     32'h300);
        waitValid(1'b1, "postrst_fetch_done");
        bus.if_req = 1'b0;
        checkOutput("postrst_if_rdata", bus.if_rdata, 32'h00000300);

`ifdef ARB_PERF_CNT_EN
        checkOutput("perf_if_count", perf_if_stall_cyc, 32'd3);
        checkOutput("perf_dm_after_reset", perf_dm_stall_cyc, 32'd0);
        @(posedge clk); #1;
        perf_vec = '{1'b0, 1'b0, 32'h48, 32'h0, 4'hF, 4, 3, 32'h0BADF00D, 10, 1'b0, 4'hF, 32'h0BADF00D, 32'h00000300};
        applyStimulus(perf_vec, "perf_load");
        checkOutput("perf_dm_count", perf_dm_stall_cyc, 32'd10);
        force dut.perf_if_stall_cyc = 32'hFFFFFFFF;
        @(posedge clk); #1;
        release dut.perf_if_stall_cyc;
        gnt_delay   = 3;
        rsp_delay   = 0;
        bus.if_addr = 32'h304;
        bus.if_req  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("perf_if_saturate", perf_if_stall_cyc, 32'hFFFFFFFF);
        waitValid(1'b1, "perf_fetch_done");
        bus.if_req = 1'b0;
        @(posedge clk); #1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
